// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, sync polarity constants and a small helper
// shared by the VGA timing generator and its axis counters.
package vga_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;

  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with enable; resets to TOTAL-1 so the first enabled
// edge lands on 0. Exposes the next value so the owner can register decoded outputs.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt;

  assign wrap = (cnt == LAST);

  always_comb begin
    nxt = cnt;
    if (en) nxt = wrap ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= LAST;
    else        cnt <= nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/position generator. All outputs are decoded from the counters' next
// values and registered, so they stay aligned. Optional VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter bit HS_POL   = POL_LOW,
  parameter bit VS_POL   = POL_LOW
) (
  input  logic                        clk25,
  input  logic                        rst_n,
  input  logic                        ce,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        vidon,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic                        line_start,
  output logic                        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int CW      = $clog2(max_int(H_TOTAL, V_TOTAL));
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);

  localparam logic [CW-1:0] H_SE = CW'(H_SYNC);
  localparam logic [CW-1:0] H_VS = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_VE = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_SE = CW'(V_SYNC);
  localparam logic [CW-1:0] V_VS = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_VE = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          h_vis, v_vis;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(CW)) u_h_cnt (
    .clk(clk25), .rst_n(rst_n), .en(ce), .nxt(h_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(CW)) u_v_cnt (
    .clk(clk25), .rst_n(rst_n), .en(ce && h_wrap), .nxt(v_nxt), .wrap(v_wrap)
  );

  assign h_vis = (h_nxt >= H_VS) && (h_nxt < H_VE);
  assign v_vis = (v_nxt >= V_VS) && (v_nxt < V_VE);

  // Registers only load on ce, so every output (strobes included) holds while ce=0.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      vidon       <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= (h_nxt < H_SE) ? HS_POL : !HS_POL;
      vsync       <= (v_nxt < V_SE) ? VS_POL : !VS_POL;
      vidon       <= h_vis && v_vis;
      x           <= (h_vis && v_vis) ? XW'(h_nxt - H_VS) : '0;
      y           <= (h_vis && v_vis) ? YW'(v_nxt - V_VS) : '0;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)                      frame_cnt <= '0;
    else if (ce && h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, a small high-active-hsync
// timing on a second instance for full frames, ce stretching and mid-frame reset.
module tb_vga_timing_gen;

  logic clk25 = 1'b0;
  logic rst_n;
  logic ce_d, ce_s;

  logic       d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [2:0] s_x;
  logic [2:0] s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk25 = ~clk25;

  vga_timing_gen dut_d (
    .clk25(clk25), .rst_n(rst_n), .ce(ce_d),
    .hsync(d_hs), .vsync(d_vs), .vidon(d_vid), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  // Small timing: H 4/3/8/2 (17 total), V 2/2/5/1 (10 total), hsync active-high.
  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .clk25(clk25), .rst_n(rst_n), .ce(ce_s),
    .hsync(s_hs), .vsync(s_vs), .vidon(s_vid), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk25);
  endtask

  int hs_low, ls_cnt, vs_low, first_vid, line_vid;
  int s_hs_act, s_vs_low, s_ls_cnt, s_vid_cnt, s_max_x, s_max_y;

  initial begin
    rst_n = 1'b0; ce_d = 1'b0; ce_s = 1'b0;
    repeat (3) tick();
    check("rst_d_hsync", d_hs, 1);
    check("rst_d_vsync", d_vs, 1);
    check("rst_d_vidon", d_vid, 0);
    check("rst_d_xy", {d_x, d_y}, 0);
    check("rst_d_strobes", {d_ls, d_fs}, 0);
    check("rst_s_hsync", s_hs, 0);

    // Default timing, ce=1 constantly; sample i is taken after the (i+1)-th edge.
    rst_n = 1'b1; ce_d = 1'b1;
    hs_low = 0; ls_cnt = 0; vs_low = 0; first_vid = -1; line_vid = 0;
    for (int i = 0; i < 26000; i++) begin
      tick();
      if (i == 0) begin
        check("d_first_fs", d_fs, 1);
        check("d_first_ls", d_ls, 1);
        check("d_first_hsync", d_hs, 0);
        check("d_first_vsync", d_vs, 0);
      end
      if (i == 1) check("d_fs_one_cycle", d_fs, 0);
      if (i < 800 && !d_hs) hs_low++;
      if (i < 1600 && d_ls) ls_cnt++;
      if (i == 800) check("d_ls_at_800", d_ls, 1);
      if (i < 2400 && !d_vs) vs_low++;
      if (d_vid && first_vid < 0) begin
        first_vid = i;
        check("d_first_x", d_x, 0);
        check("d_first_y", d_y, 0);
      end
      if (i >= 24800 && i < 25600 && d_vid) line_vid++;
      if (i == 24944 + 639) check("d_x_max", d_x, 639);
      if (i == 24944 + 640) check("d_vid_end", {d_vid, d_x}, 0);
      if (i == 24944 + 800) check("d_y_next", {d_vid, 1'b0, d_x, d_y}, {1'b1, 11'd0, 9'd1});
    end
    check("d_hsync_low_width", hs_low, 96);
    check("d_line_start_count", ls_cnt, 2);
    check("d_vsync_low_width", vs_low, 1600);
    check("d_first_vid_cycle", first_vid, 24944);
    check("d_vid_per_line", line_vid, 640);

    // Freeze at h=399, v=32: x=255, y=1.
    ce_d = 1'b0;
    repeat (5) tick();
    check("d_frozen_x", d_x, 255);
    check("d_frozen_y", d_y, 1);
    check("d_frozen_vid_hs", {d_vid, d_hs, d_ls}, 3'b110);

    // Small timing, ce toggling 1/0: position advances on even samples only.
    s_hs_act = 0; s_vs_low = 0; s_ls_cnt = 0; s_vid_cnt = 0; s_max_x = 0; s_max_y = 0;
    for (int j = 0; j < 340; j++) begin
      ce_s = (j % 2 == 0);
      tick();
      if (s_hs) s_hs_act++;
      if (!s_vs) s_vs_low++;
      if (s_ls) s_ls_cnt++;
      if (s_vid) s_vid_cnt++;
      if (int'(s_x) > s_max_x) s_max_x = int'(s_x);
      if (int'(s_y) > s_max_y) s_max_y = int'(s_y);
      if (j == 1) check("s_fs_stretched", s_fs, 1);
      if (j == 2) check("s_fs_drop", s_fs, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (j == 2) check("s_frame_cnt_1", s_fc, 1);
`endif
      if (j == 149) check("s_vid_before", s_vid, 0);
      if (j == 150) check("s_vid_first", {s_vid, s_x, s_y}, {1'b1, 6'd0});
      if (j == 151) check("s_vid_hold", {s_vid, s_x, s_y}, {1'b1, 6'd0});
    end
    check("s_hsync_active_cycles", s_hs_act, 80);
    check("s_vsync_low_cycles", s_vs_low, 68);
    check("s_line_start_cycles", s_ls_cnt, 20);
    check("s_vidon_cycles", s_vid_cnt, 80);
    check("s_max_x", s_max_x, 7);
    check("s_max_y", s_max_y, 4);
    ce_s = 1'b1;
    tick();
    check("s_frame_period", s_fs, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("s_frame_cnt_2", s_fc, 2);
`endif

    // Run to h=10, v=6 of the second frame, then reset mid-frame.
    repeat (112) tick();
    check("s_mid_pos", {s_vid, s_x, s_y}, {1'b1, 3'd3, 3'd2});
    check("s_mid_sync", {s_hs, s_vs}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("s_async_rst", {s_vid, s_x, s_y, s_hs, s_vs, s_ls, s_fs}, 11'b0_000_000_0100);
    tick();
    rst_n = 1'b1;
    tick();
    check("s_restart", {s_fs, s_ls, s_hs, s_vs, s_vid, s_x}, {5'b11100, 3'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_SYNC, default 96, hsync pulse width in pixels SHALL be configurable.
REQ-002 Parameter H_BP, default 48, horizontal back porch in pixels SHALL be configurable.
REQ-003 Parameter H_ACTIVE, default 640, visible pixels per line SHALL be configurable.
REQ-004 Parameter H_FP, default 16, horizontal front porch in pixels SHALL be configurable.
REQ-005 Parameter V_SYNC, default 2, vsync pulse width in lines SHALL be configurable.
REQ-006 Parameter V_BP, default 29, vertical back porch in lines SHALL be configurable.
REQ-007 Parameter V_ACTIVE, default 480, visible lines SHALL be configurable.
REQ-008 Parameter V_FP, default 10, vertical front porch in lines SHALL be configurable.
REQ-009 Parameter HS_POL / VS_POL, default 0, SHALL set the asserted sync level (0 = active-low).
REQ-010 clk25  input  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-011 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-012 ce  input  1  SHALL be the pixel enable; the state SHALL advance only on edges where ce=1.
REQ-013 hsync / vsync  output  1  SHALL carry the sync pulses at HS_POL / VS_POL.
REQ-014 vidon  output  1  SHALL be high only inside the active area.
REQ-015 x  output  $clog2(H_ACTIVE)  SHALL give the active column; y  output  $clog2(V_ACTIVE)  SHALL give the active row.
REQ-016 line_start / frame_start  output  1  SHALL be one-ce-period strobes.

Function
REQ-017 Line SHALL be ordered sync, back porch, active, front porch; H_TOTAL = sum of the four H parameters; V likewise.
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL advance by one only on the h_cnt wrap, and SHALL wrap to 0 after V_TOTAL-1.
REQ-019 Counter width SHALL be $clog2 of the larger total; no overflow is permitted at any legal parameter set.
REQ-020 All outputs SHALL be registered and SHALL describe the counter value held in the same cycle (zero skew between outputs).
REQ-021 hsync SHALL be asserted for h_cnt < H_SYNC; vsync SHALL be asserted for v_cnt < V_SYNC.
REQ-022 vidon SHALL be high for H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and the same window on v_cnt.
REQ-023 x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) when vidon=1; x and y SHALL read 0 when vidon=0.
REQ-024 line_start SHALL be high while h_cnt=0; frame_start SHALL be high while h_cnt=0 and v_cnt=0.
REQ-025 With ce=0, all counters and outputs SHALL hold; strobes SHALL therefore stretch over ce-low cycles.

Reset
REQ-026 On rst_n=0, h_cnt SHALL be H_TOTAL-1 and v_cnt SHALL be V_TOTAL-1, asynchronously; hsync/vsync SHALL be deasserted, vidon=0, x=0, y=0, and the strobes SHALL be 0.
REQ-027 The first ce edge after release SHALL produce position (0,0) with frame_start=1; reset mid-frame SHALL restart the frame identically.

Configuration
REQ-028 With VGA_TIMING_FRAME_CNT_EN defined, a 16-bit output frame_cnt SHALL reset to 0, SHALL increment on each frame_start, and SHALL wrap at 65535.
REQ-029 Without VGA_TIMING_FRAME_CNT_EN, the port and the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package vga_pkg SHALL hold the default 640x480 timing constants and the polarity constants.
REQ-031 Sub-module vga_axis_counter (a wrapping counter with an enable, a wrap flag and a reset value of TOTAL-1) SHALL be instantiated once for H and once for V.

Verification
REQ-032 Reset release, ce=1 constantly -> frame_start on the 1st edge; hsync low for 96 cycles; line_start every 800 cycles.
REQ-033 Full frame -> exactly 640x480 vidon cycles; x runs 0..639 starting at h_cnt=144; y runs 0..479 starting at v_cnt=31.
REQ-034 Frame boundary -> frame_start period is 800*521=416800 cycles; vsync low for 2 lines (1600 cycles).
REQ-035 ce toggling 1/0 -> output waveform identical to the ce=1 case, stretched by 2x; outputs frozen when ce=0.
REQ-036 rst_n asserted mid-line (h_cnt=300, v_cnt=200) -> outputs immediately at reset values; restart at (0,0).
REQ-037 HS_POL=1, H_ACTIVE=800, VGA_TIMING_FRAME_CNT_EN defined -> hsync high-active, x reaches 799, frame_cnt=3 after 3 frames.
